phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer_pkg.sv | 36 +++
 rtl/phase_sequencer_wait_timer.sv | 41 ++++
 rtl/phase_sequencer.sv | 151 +++++++++++++++
 tb/tb_phase_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared CPU package: sequencer state encoding, run mode and sizing constants
// used by the phase sequencer and the instruction decoder.
package phase_sequencer_pkg;

    // Sequencer states; the decoder keys its phase behaviour off these names.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC1 = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_HALT  = 3'd4,
        ST_FAULT = 3'd5
    } seq_state_t;

    // Mode latched when leaving IDLE: step runs one instruction, continuous
    // keeps fetching while RUN stays high.
    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_CONT = 1'b1
    } run_mode_t;

    // Default number of consecutive MEM_ready-low cycles tolerated.
    localparam int TIMEOUT_DEFAULT = 255;

    // Wait counter width; holds any legal TIMEOUT (1..255).
    localparam int WAIT_W = 8;

    // Retired-instruction counter width.
    localparam int COUNT_W = 16;

    // True for the three phases that perform a memory access.
    function automatic logic is_busy(input seq_state_t s);
        return (s == ST_FETCH) || (s == ST_EXEC1) || (s == ST_EXEC2);
    endfunction

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// Memory wait watchdog: counts consecutive stalled cycles inside a busy phase
// and flags expiry in the cycle that would make the count reach TIMEOUT.
module wait_timer
    import phase_sequencer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic active,        // sequencer is in FETCH, EXEC1 or EXEC2
    input  logic mem_ready,     // memory access completes this cycle
    input  logic state_change,  // sequencer leaves its current state at this edge
    output logic expired        // this stalled cycle is the TIMEOUT-th in a row
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Expiry counts the current stalled cycle, so compare against TIMEOUT-1.
    assign expired = active && !mem_ready && (cnt_q == LIMIT);

    // Extend the run of stalled cycles; any progress or state change restarts it.
    always_comb begin
        cnt_d = '0;
        if (active && !mem_ready && !state_change) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: steps FETCH -> EXEC1 [-> EXEC2] per instruction
// in step or continuous mode, counts retired instructions, stops for good on a
// stop instruction (HALT) or a memory wait timeout (FAULT) until reset.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RUN,
    input  logic               STEP,
    input  logic               E2,
    input  logic               STP,
    input  logic               MEM_ready,
    output logic               FETCH,
    output logic               EXEC1,
    output logic               EXEC2,
    output logic               HALTED,
    output logic               FAULT,
    output logic               BUSY,
    output logic [COUNT_W-1:0] INSTR_count,
    output seq_state_t         state_dbg
);

    seq_state_t         state_q, state_d;
    run_mode_t          mode_q, mode_d;
    logic [COUNT_W-1:0] instr_count_q, instr_count_d;
    logic               fetch_q, fetch_d;
    logic               exec1_q, exec1_d;
    logic               exec2_q, exec2_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;
    logic               busy_q, busy_d;
    logic               retire;
    logic               timeout_hit;
    logic               state_change;

    assign state_change = (state_d != state_q);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk          (CLK),
        .rst          (RST),
        .active       (is_busy(state_q)),
        .mem_ready    (MEM_ready),
        .state_change (state_change),
        .expired      (timeout_hit)
    );

    // Next state, run mode, retire count and output strobes; the timeout
    // overrides every phase rule, including a stop seen while stalled.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        instr_count_d = instr_count_q;
        retire        = 1'b0;

        if (timeout_hit) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (RUN) begin
                        state_d = ST_FETCH;
                        mode_d  = MODE_CONT;
                    end else if (STEP) begin
                        state_d = ST_FETCH;
                        mode_d  = MODE_STEP;
                    end
                end
                ST_FETCH: begin
                    if (MEM_ready) begin
                        state_d = ST_EXEC1;
                    end
                end
                ST_EXEC1: begin
                    if (STP) begin
                        state_d       = ST_HALT;
                        instr_count_d = instr_count_q + 1'b1;
                    end else if (MEM_ready) begin
                        if (E2) begin
                            state_d = ST_EXEC2;
                        end else begin
                            retire = 1'b1;
                        end
                    end
                end
                ST_EXEC2: begin
                    if (MEM_ready) begin
                        retire = 1'b1;
                    end
                end
                ST_HALT, ST_FAULT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end

        if (retire) begin
            state_d       = (mode_q == MODE_CONT && RUN) ? ST_FETCH : ST_IDLE;
            instr_count_d = instr_count_q + 1'b1;
        end

        fetch_d  = (state_d == ST_FETCH);
        exec1_d  = (state_d == ST_EXEC1);
        exec2_d  = (state_d == ST_EXEC2);
        halted_d = (state_d == ST_HALT);
        fault_d  = (state_d == ST_FAULT);
        busy_d   = is_busy(state_d);
    end

    // Sequencer state and registered outputs; reset wins over every input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_STEP;
            instr_count_q <= '0;
            fetch_q       <= 1'b0;
            exec1_q       <= 1'b0;
            exec2_q       <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            instr_count_q <= instr_count_d;
            fetch_q       <= fetch_d;
            exec1_q       <= exec1_d;
            exec2_q       <= exec2_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            busy_q        <= busy_d;
        end
    end

    assign FETCH       = fetch_q;
    assign EXEC1       = exec1_q;
    assign EXEC2       = exec2_q;
    assign HALTED      = halted_q;
    assign FAULT       = fault_q;
    assign BUSY        = busy_q;
    assign INSTR_count = instr_count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer (TIMEOUT=4): directed vector tables, a counter
// wrap sequence, then random stimulus against a phase-level reference model.
module tb_phase_sequencer;
    import phase_sequencer_pkg::*;

    localparam int TO = 4;

    // Phase names used by the tables and the model.
    localparam int P_IDLE  = 0;
    localparam int P_F     = 1;
    localparam int P_E1    = 2;
    localparam int P_E2    = 3;
    localparam int P_HALT  = 4;
    localparam int P_FAULT = 5;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst, run, step, e2, stp, rdy;
    logic fetch, exec1, exec2, halted, fault, busy;
    logic [15:0] icnt;
    seq_state_t state_dbg;

    always #5 clk = ~clk;

    phase_sequencer #(
        .TIMEOUT (TO)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .RUN         (run),
        .STEP        (step),
        .E2          (e2),
        .STP         (stp),
        .MEM_ready   (rdy),
        .FETCH       (fetch),
        .EXEC1       (exec1),
        .EXEC2       (exec2),
        .HALTED      (halted),
        .FAULT       (fault),
        .BUSY        (busy),
        .INSTR_count (icnt),
        .state_dbg   (state_dbg)
    );

    logic [21:0] act;
    assign act = {fetch, exec1, exec2, halted, fault, busy, icnt};

    // ---------------- scoreboard ----------------
    logic [21:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [21:0] pack_exp(input int p, input int c);
        logic f, x1, x2, h, ft;
        f  = (p == P_F);
        x1 = (p == P_E1);
        x2 = (p == P_E2);
        h  = (p == P_HALT);
        ft = (p == P_FAULT);
        return {f, x1, x2, h, ft, (f | x1 | x2), 16'(c)};
    endfunction

    task automatic check_front(input string name);
        logic [21:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: expected queue empty, got %h", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_errors++;
                $display("FAIL %s: got %h (F E1 E2 H FLT B CNT) required %h", name, act, e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r, ru, s, x2, sp, rd);
        rst  = r;
        run  = ru;
        step = s;
        e2   = x2;
        stp  = sp;
        rdy  = rd;
    endtask

    // Inputs are already on the pins; let one edge pass and check at negedge.
    task automatic cycle(input string name, input logic [21:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        check_front(name);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        bit rst;
        bit run;
        bit step;
        bit e2;
        bit stp;
        bit rdy;
        int phase;
        int cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, ru, s, x2, sp, rd, input int p, input int c);
        vec_t v;
        v.rst = r; v.run = ru; v.step = s; v.e2 = x2; v.stp = sp; v.rdy = rd;
        v.phase = p; v.cnt = c;
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    int m_phase, m_wait, m_count;
    bit m_cont;

    task automatic model_tick(input bit r, ru, s, x2, sp, rd);
        int nxt;
        bit in_access, retire, timed_out;
        if (r) begin
            m_phase = P_IDLE; m_cont = 0; m_wait = 0; m_count = 0;
            return;
        end
        in_access = (m_phase == P_F) || (m_phase == P_E1) || (m_phase == P_E2);
        timed_out = in_access && !rd && (m_wait + 1 >= TO);
        nxt = m_phase;
        retire = 0;
        if (timed_out) begin
            nxt = P_FAULT;
        end else if (m_phase == P_IDLE) begin
            if (ru || s) begin
                nxt = P_F;
                m_cont = ru;
            end
        end else if (m_phase == P_F) begin
            if (rd) nxt = P_E1;
        end else if (m_phase == P_E1) begin
            if (sp) begin
                nxt = P_HALT;
                m_count = (m_count + 1) % 65536;
            end else if (rd) begin
                if (x2) nxt = P_E2;
                else retire = 1;
            end
        end else if (m_phase == P_E2) begin
            if (rd) retire = 1;
        end
        if (retire) begin
            nxt = (m_cont && ru) ? P_F : P_IDLE;
            m_count = (m_count + 1) % 65536;
        end
        if (nxt != m_phase) m_wait = 0;
        else if (in_access && !rd) m_wait++;
        else m_wait = 0;
        m_phase = nxt;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        drive(1, 0, 0, 0, 0, 1);
        @(negedge clk);

        // continuous run without EXEC2, then RUN dropped mid-instruction
        add(1,0,0,0,0,1, P_IDLE, 0);
        for (int k = 0; k < 4; k++) begin
            add(0,1,0,0,0,1, P_F, k);
            add(0,1,0,0,0,1, P_E1, k);
        end
        add(0,1,0,0,0,1, P_F, 4);
        add(0,0,0,0,0,1, P_E1, 4);
        add(0,0,0,0,0,1, P_IDLE, 5);
        add(0,0,0,0,0,1, P_IDLE, 5);
        // continuous run with EXEC2
        add(1,0,0,0,0,1, P_IDLE, 0);
        for (int k = 0; k < 3; k++) begin
            add(0,1,0,1,0,1, P_F, k);
            add(0,1,0,1,0,1, P_E1, k);
            add(0,1,0,1,0,1, P_E2, k);
        end
        add(0,1,0,1,0,1, P_F, 3);
        // single step; a second STEP during EXEC1 is dropped
        add(1,0,0,0,0,1, P_IDLE, 0);
        add(0,0,1,0,0,1, P_F, 0);
        add(0,0,0,0,0,1, P_E1, 0);
        add(0,0,1,0,0,1, P_IDLE, 1);
        add(0,0,0,0,0,1, P_IDLE, 1);
        add(0,0,0,0,0,1, P_IDLE, 1);
        // step mode ignores RUN raised mid-instruction until back in IDLE
        add(0,0,1,0,0,1, P_F, 1);
        add(0,1,0,0,0,1, P_E1, 1);
        add(0,1,0,0,0,1, P_IDLE, 2);
        add(0,1,0,0,0,1, P_F, 2);
        // RUN and STEP together select continuous mode
        add(1,0,0,0,0,1, P_IDLE, 0);
        add(0,1,1,0,0,1, P_F, 0);
        add(0,1,0,0,0,1, P_E1, 0);
        add(0,1,0,0,0,1, P_F, 1);
        // stop in second EXEC1 (with MEM_ready low, E2 high); HALT is sticky
        add(1,0,0,0,0,1, P_IDLE, 0);
        add(0,1,0,0,0,1, P_F, 0);
        add(0,1,0,0,0,1, P_E1, 0);
        add(0,1,0,0,0,1, P_F, 1);
        add(0,1,0,0,0,1, P_E1, 1);
        add(0,1,0,1,1,0, P_HALT, 2);
        add(0,1,1,0,0,1, P_HALT, 2);
        add(0,0,1,0,0,1, P_HALT, 2);
        add(0,0,0,0,0,0, P_HALT, 2);
        add(1,1,1,0,0,1, P_IDLE, 0);
        // timeout after 4 stalled FETCH cycles; FAULT is sticky
        add(0,0,1,0,0,0, P_F, 0);
        add(0,0,0,0,0,0, P_F, 0);
        add(0,0,0,0,0,0, P_F, 0);
        add(0,0,0,0,0,0, P_F, 0);
        add(0,0,0,0,0,0, P_FAULT, 0);
        add(0,1,1,0,0,1, P_FAULT, 0);
        add(1,0,0,0,0,1, P_IDLE, 0);
        // 3 stalled cycles in FETCH and EXEC1 are tolerated
        add(0,0,1,0,0,0, P_F, 0);
        add(0,0,0,0,0,0, P_F, 0);
        add(0,0,0,0,0,0, P_F, 0);
        add(0,0,0,0,0,0, P_F, 0);
        add(0,0,0,0,0,1, P_E1, 0);
        add(0,0,0,0,0,0, P_E1, 0);
        add(0,0,0,0,0,0, P_E1, 0);
        add(0,0,0,0,0,0, P_E1, 0);
        add(0,0,0,0,0,1, P_IDLE, 1);
        // timeout in EXEC2
        add(0,1,0,1,0,1, P_F, 1);
        add(0,1,0,1,0,1, P_E1, 1);
        add(0,1,0,1,0,1, P_E2, 1);
        add(0,1,0,0,0,0, P_E2, 1);
        add(0,1,0,0,0,0, P_E2, 1);
        add(0,1,0,0,0,0, P_E2, 1);
        add(0,1,0,0,0,0, P_FAULT, 1);
        // reset during EXEC2 with a nonzero count
        add(1,0,0,0,0,1, P_IDLE, 0);
        add(0,1,0,1,0,1, P_F, 0);
        add(0,1,0,1,0,1, P_E1, 0);
        add(0,1,0,1,0,1, P_E2, 0);
        add(0,1,0,1,0,1, P_F, 1);
        add(0,1,0,1,0,1, P_E1, 1);
        add(0,1,0,1,0,1, P_E2, 1);
        add(1,1,0,1,0,1, P_IDLE, 0);
        add(0,0,0,0,0,1, P_IDLE, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].run, tbl[i].step, tbl[i].e2, tbl[i].stp, tbl[i].rdy);
            cycle($sformatf("vec%0d", i), pack_exp(tbl[i].phase, tbl[i].cnt));
        end

        // counter wrap: preload near the top, then retire through 16'hFFFF
        drive(1, 0, 0, 0, 0, 1);
        cycle("wrap_rst", pack_exp(P_IDLE, 0));
        drive(0, 0, 0, 0, 0, 1);
        force dut.instr_count_q = 16'hFFFE;
        #1;
        release dut.instr_count_q;
        drive(0, 1, 0, 0, 0, 1);
        cycle("wrap_f0",  pack_exp(P_F,  16'hFFFE));
        cycle("wrap_e0",  pack_exp(P_E1, 16'hFFFE));
        cycle("wrap_f1",  pack_exp(P_F,  16'hFFFF));
        cycle("wrap_e1",  pack_exp(P_E1, 16'hFFFF));
        cycle("wrap_f2",  pack_exp(P_F,  0));

        // randomized run against the reference model
        drive(1, 0, 0, 0, 0, 1);
        model_tick(1, 0, 0, 0, 0, 1);
        cycle("rand_rst", pack_exp(m_phase, m_count));
        begin
            bit r, ru, s, x2, sp, rd;
            int low_burst;
            low_burst = 0;
            ru = 0;
            for (int n = 0; n < 4000; n++) begin
                if (low_burst > 0) begin
                    rd = 0;
                    low_burst--;
                end else begin
                    rd = ($urandom_range(0, 7) != 0);
                    if ($urandom_range(0, 30) == 0) low_burst = $urandom_range(2, 6);
                end
                r  = ($urandom_range(0, 149) == 0) ||
                     (((m_phase == P_HALT) || (m_phase == P_FAULT)) && ($urandom_range(0, 5) == 0));
                if ($urandom_range(0, 9) == 0) ru = !ru;
                s  = ($urandom_range(0, 3) == 0);
                x2 = ($urandom_range(0, 1) == 1);
                sp = ($urandom_range(0, 24) == 0);
                drive(r, ru, s, x2, sp, rd);
                model_tick(r, ru, s, x2, sp, rd);
                cycle("rand", pack_exp(m_phase, m_count));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
